// File: rtl/img_stream_pkg.sv
// rtl/img_stream_pkg.sv - shared state encoding and timing constants for the image stream generator
package img_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VPRE   = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_VPOST  = 3'd3,
        ST_VGAP   = 3'd4
    } state_e;

    localparam logic [10:0] DEF_HDISP  = 11'd640;
    localparam logic [10:0] DEF_HBLANK = 11'd160;
    localparam logic [10:0] LINE_LEN   = DEF_HDISP + DEF_HBLANK;

    // Clocks from internal timing to img_* outputs; downstream delay matching keys off this.
    localparam int PIPE_LAT = 2;

    function automatic logic [10:0] line_len(input logic [10:0] hdisp, input logic [10:0] hblank);
        return hdisp + hblank;
    endfunction

endpackage

// File: rtl/img_stream_gen_if.sv
// rtl/img_stream_gen_if.sv - frame-memory read port and vsync/href/gray pixel stream
interface img_stream_gen_if #(
    parameter int ADDR_W = 19
) ();
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [7:0]        mem_rd_data;
    logic              img_vsync;
    logic              img_href;
    logic [7:0]        img_gray;

    modport master (
        output mem_rd_en, mem_rd_addr, img_vsync, img_href, img_gray,
        input  mem_rd_data
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr, img_vsync, img_href, img_gray,
        output mem_rd_data
    );
endinterface

// File: rtl/img_timing_cnt.sv
// rtl/img_timing_cnt.sv - pixel/line counters with state-end flag for the stream generator
module img_timing_cnt
    import img_stream_pkg::*;
#(
    parameter logic [10:0] LINE_LEN_P = LINE_LEN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [10:0] state_lines,
    output logic [10:0] hcnt,
    output logic        state_end
);

    logic [10:0] hcnt_q, hcnt_d;
    logic [10:0] vcnt_q, vcnt_d;
    logic        line_end;

    always_comb begin
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        line_end  = (hcnt_q == LINE_LEN_P - 11'd1);
        state_end = line_end && (vcnt_q == state_lines - 11'd1);
        if (!run) begin
            hcnt_d = 11'd0;
            vcnt_d = 11'd0;
        end else if (line_end) begin
            hcnt_d = 11'd0;
            vcnt_d = state_end ? 11'd0 : vcnt_q + 11'd1;
        end else begin
            hcnt_d = hcnt_q + 11'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q <= 11'd0;
            vcnt_q <= 11'd0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign hcnt = hcnt_q;

endmodule

// File: rtl/img_stream_gen.sv
// rtl/img_stream_gen.sv - frame playback source producing vsync/href/gray with programmable blanking
module img_stream_gen
    import img_stream_pkg::*;
#(
    parameter logic [10:0] IMG_HDISP = DEF_HDISP,
    parameter logic [10:0] IMG_VDISP = 11'd480,
    parameter logic [10:0] H_BLANK   = DEF_HBLANK,
    parameter logic [7:0]  V_PRE     = 8'd2,
    parameter logic [7:0]  V_POST    = 8'd2,
    parameter logic [7:0]  V_GAP     = 8'd4,
    parameter int          ADDR_W    = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    output logic             busy,
    output logic             frame_done,
    img_stream_gen_if.master vid
);

    localparam logic [10:0]       LLEN      = line_len(IMG_HDISP, H_BLANK);
    localparam int                NPIX      = int'(IMG_HDISP) * int'(IMG_VDISP);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [PIPE_LAT-1:0] vs_pipe_q, vs_pipe_d;
    logic [PIPE_LAT-1:0] hr_pipe_q, hr_pipe_d;
    logic [7:0]          gray_q, gray_d;
    logic                frame_done_q, frame_done_d;

    logic [10:0] hcnt;
    logic [10:0] state_lines;
    logic        state_end;
    logic        href_i;
    logic        vsync_i;
    logic        restart;

    img_timing_cnt #(
        .LINE_LEN_P (LLEN)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (state_q != ST_IDLE),
        .state_lines (state_lines),
        .hcnt        (hcnt),
        .state_end   (state_end)
    );

    always_comb begin
        state_d     = state_q;
        restart     = 1'b0;
        state_lines = 11'd1;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_VPRE;
                    restart = 1'b1;
                end
            end
            ST_VPRE: begin
                state_lines = {3'b000, V_PRE};
                if (state_end) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                state_lines = IMG_VDISP;
                if (state_end) state_d = (V_POST == 8'd0) ? ST_VGAP : ST_VPOST;
            end
            ST_VPOST: begin
                state_lines = {3'b000, V_POST};
                if (state_end) state_d = ST_VGAP;
            end
            ST_VGAP: begin
                state_lines = {3'b000, V_GAP};
                if (state_end) begin
                    state_d = cont ? ST_VPRE : ST_IDLE;
                    restart = cont;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    assign href_i  = (state_q == ST_ACTIVE) && (hcnt < IMG_HDISP);
    assign vsync_i = (state_q == ST_VPRE) || (state_q == ST_ACTIVE) || (state_q == ST_VPOST);

    // The address saturates on the final pixel so it never leaves the frame.
    always_comb begin
        addr_d = addr_q;
        if (restart) begin
            addr_d = '0;
        end else if (href_i && (addr_q != LAST_ADDR)) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    always_comb begin
        vs_pipe_d    = {vs_pipe_q[PIPE_LAT-2:0], vsync_i};
        hr_pipe_d    = {hr_pipe_q[PIPE_LAT-2:0], href_i};
        gray_d       = hr_pipe_q[PIPE_LAT-2] ? vid.mem_rd_data : 8'd0;
        frame_done_d = vs_pipe_q[PIPE_LAT-1] && !vs_pipe_q[PIPE_LAT-2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            vs_pipe_q    <= '0;
            hr_pipe_q    <= '0;
            gray_q       <= 8'd0;
            frame_done_q <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            vs_pipe_q    <= vs_pipe_d;
            hr_pipe_q    <= hr_pipe_d;
            gray_q       <= gray_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign busy            = (state_q != ST_IDLE);
    assign frame_done      = frame_done_q;
    assign vid.mem_rd_en   = href_i;
    assign vid.mem_rd_addr = addr_q;
    assign vid.img_vsync   = vs_pipe_q[PIPE_LAT-1];
    assign vid.img_href    = hr_pipe_q[PIPE_LAT-1];
    assign vid.img_gray    = gray_q;

endmodule

// File: tb/tb_img_stream_gen.sv
// tb/tb_img_stream_gen.sv - scoreboard bench for img_stream_gen (small frame, V_POST=1 and V_POST=0)
module tb_img_stream_gen;

    localparam int AW   = 4;
    localparam int NPIX = 12;
    localparam int HD   = 4;
    localparam int HB   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic cont = 1'b0;
    logic busy_a, busy_b, fd_a, fd_b;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    img_stream_gen_if #(.ADDR_W(AW)) ifa ();
    img_stream_gen_if #(.ADDR_W(AW)) ifb ();

    img_stream_gen #(
        .IMG_HDISP(11'd4), .IMG_VDISP(11'd3), .H_BLANK(11'd2),
        .V_PRE(8'd1), .V_POST(8'd1), .V_GAP(8'd2), .ADDR_W(AW)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .cont(cont),
        .busy(busy_a), .frame_done(fd_a), .vid(ifa)
    );

    img_stream_gen #(
        .IMG_HDISP(11'd4), .IMG_VDISP(11'd3), .H_BLANK(11'd2),
        .V_PRE(8'd1), .V_POST(8'd0), .V_GAP(8'd2), .ADDR_W(AW)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .cont(1'b0),
        .busy(busy_b), .frame_done(fd_b), .vid(ifb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [16];
    initial for (int i = 0; i < 16; i++) mem[i] = 8'(i + 16);

    always @(posedge clk) begin
        if (ifa.mem_rd_en) ifa.mem_rd_data <= mem[ifa.mem_rd_addr];
        if (ifb.mem_rd_en) ifb.mem_rd_data <= mem[ifb.mem_rd_addr];
    end

    logic           vs_s [2];
    logic           hr_s [2];
    logic           fd_s [2];
    logic           en_s [2];
    logic [7:0]     gy_s [2];
    logic [AW-1:0]  ad_s [2];

    always_comb begin
        vs_s[0] = ifa.img_vsync;  vs_s[1] = ifb.img_vsync;
        hr_s[0] = ifa.img_href;   hr_s[1] = ifb.img_href;
        fd_s[0] = fd_a;           fd_s[1] = fd_b;
        en_s[0] = ifa.mem_rd_en;  en_s[1] = ifb.mem_rd_en;
        gy_s[0] = ifa.img_gray;   gy_s[1] = ifb.img_gray;
        ad_s[0] = ifa.mem_rd_addr; ad_s[1] = ifb.mem_rd_addr;
    end

    logic [7:0] exp_px0 [$];
    logic [7:0] exp_px1 [$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int prev_vs [2], in_fr [2], hi_len [2], first_off [2], nb [2], shape_bad [2];
    int run_hi [2], run_lo [2], rd_cnt [2], cur_rise [2], fr_cnt [2], fd_cnt [2];
    int rec_hi [2][8], rec_off [2][8], rec_nb [2][8], rec_bad [2][8];
    int rec_rd [2][8], rec_tail [2][8], rec_rise [2][8], rec_fall [2][8];

    // Monitor: pixel scoreboard, address model, frame_done edge model, per-frame shape records.
    initial begin
        for (int d = 0; d < 2; d++) begin
            prev_vs[d] = 0; in_fr[d] = 0; fr_cnt[d] = 0; fd_cnt[d] = 0;
            run_hi[d] = 0; run_lo[d] = 0; rd_cnt[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    prev_vs[d] = 0; in_fr[d] = 0; run_hi[d] = 0; run_lo[d] = 0;
                end else begin
                    if (fd_s[d] || (prev_vs[d] != 0 && !vs_s[d]))
                        check("frame_done_edge", int'(fd_s[d]), int'(prev_vs[d] != 0 && !vs_s[d]));
                    if (fd_s[d]) fd_cnt[d]++;

                    if (hr_s[d]) begin
                        if ((d == 0 && exp_px0.size() == 0) || (d == 1 && exp_px1.size() == 0)) begin
                            total++; bad++;
                            $display("FAIL pixel_unexpected: dut %0d got %0d with empty queue", d, gy_s[d]);
                        end else begin
                            logic [7:0] e;
                            e = (d == 0) ? exp_px0.pop_front() : exp_px1.pop_front();
                            check("pixel", int'(gy_s[d]), int'(e));
                        end
                    end

                    if (vs_s[d] && prev_vs[d] == 0) begin
                        in_fr[d] = 1; hi_len[d] = 0; first_off[d] = -1; nb[d] = 0;
                        shape_bad[d] = 0; run_hi[d] = 0; run_lo[d] = 0; rd_cnt[d] = 0;
                        cur_rise[d] = cyc;
                    end else if (!vs_s[d] && prev_vs[d] != 0 && in_fr[d] != 0) begin
                        if (fr_cnt[d] < 8) begin
                            rec_hi[d][fr_cnt[d]]   = hi_len[d];
                            rec_off[d][fr_cnt[d]]  = first_off[d];
                            rec_nb[d][fr_cnt[d]]   = nb[d];
                            rec_bad[d][fr_cnt[d]]  = shape_bad[d];
                            rec_rd[d][fr_cnt[d]]   = rd_cnt[d];
                            rec_tail[d][fr_cnt[d]] = run_lo[d];
                            rec_rise[d][fr_cnt[d]] = cur_rise[d];
                            rec_fall[d][fr_cnt[d]] = cyc;
                        end
                        fr_cnt[d]++;
                        in_fr[d] = 0;
                    end

                    if (in_fr[d] != 0 && vs_s[d]) begin
                        if (hr_s[d]) begin
                            if (first_off[d] < 0) first_off[d] = hi_len[d];
                            if (run_hi[d] == 0 && nb[d] > 0 && run_lo[d] != HB) shape_bad[d]++;
                            run_hi[d]++;
                            run_lo[d] = 0;
                        end else begin
                            if (run_hi[d] > 0) begin
                                nb[d]++;
                                if (run_hi[d] != HD) shape_bad[d]++;
                                run_hi[d] = 0;
                            end
                            run_lo[d]++;
                        end
                        hi_len[d]++;
                    end

                    if (in_fr[d] != 0) begin
                        check("rd_addr", int'(ad_s[d]), (rd_cnt[d] < NPIX) ? rd_cnt[d] : NPIX - 1);
                        if (en_s[d]) begin
                            if (rd_cnt[d] >= NPIX) check("rd_count_overrun", rd_cnt[d] + 1, NPIX);
                            rd_cnt[d]++;
                        end
                    end
                end
                prev_vs[d] = vs_s[d] ? 1 : 0;
            end
        end
    end

    task automatic push_frame(input int d);
        for (int i = 0; i < NPIX; i++) begin
            if (d == 0) exp_px0.push_back(8'(8'h10 + i));
            else        exp_px1.push_back(8'(8'h10 + i));
        end
    endtask

    task automatic pulse_start(input int d, output int sc);
        @(negedge clk);
        if (d == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        sc = cyc;
    endtask

    task automatic wait_idle(input int d, output int hi_cycles);
        hi_cycles = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (((d == 0) ? busy_a : busy_b) == 1'b0) return;
            hi_cycles++;
        end
        check("busy_timeout", hi_cycles, -1);
    endtask

    task automatic wait_frames(input int d, input int n);
        for (int i = 0; i < 600; i++) begin
            if (fr_cnt[d] >= n) return;
            @(negedge clk);
        end
        check("frame_timeout", fr_cnt[d], n);
    endtask

    task automatic check_frame(input int d, input int k, input int exp_hi, input int exp_tail);
        check("vsync_high_len", rec_hi[d][k], exp_hi);
        check("first_href_offset", rec_off[d][k], 6);
        check("href_bursts", rec_nb[d][k], 3);
        check("burst_shape_errors", rec_bad[d][k], 0);
        check("reads_per_frame", rec_rd[d][k], NPIX);
        check("href_to_vsync_fall", rec_tail[d][k], exp_tail);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vsync"}, int'(ifa.img_vsync), 0);
        check({tag, "_href"}, int'(ifa.img_href), 0);
        check({tag, "_gray"}, int'(ifa.img_gray), 0);
        check({tag, "_busy"}, int'(busy_a), 0);
        check({tag, "_frame_done"}, int'(fd_a), 0);
        check({tag, "_rd_en"}, int'(ifa.mem_rd_en), 0);
        check({tag, "_rd_addr"}, int'(ifa.mem_rd_addr), 0);
        check({tag, "_b_busy"}, int'(busy_b), 0);
        check({tag, "_b_vsync"}, int'(ifb.img_vsync), 0);
    endtask

    task automatic check_idle(input string tag, input int n);
        int act;
        act = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (ifa.img_vsync || ifa.img_href || busy_a || ifa.mem_rd_en || fd_a) act++;
        end
        check(tag, act, 0);
    endtask

    initial begin
        int sc, sc2, hc;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #2; rst_n = 1'b1;
        check_idle("idle_after_power_on", 10);

        push_frame(0);
        pulse_start(0, sc);
        wait_idle(0, hc);
        check("single_busy_len", hc, 42);
        check("single_frames", fr_cnt[0], 1);
        check("single_vsync_latency", rec_rise[0][0] - sc, 2);
        check_frame(0, 0, 30, 8);
        check("single_frame_done", fd_cnt[0], 1);

        cont = 1'b1;
        push_frame(0);
        push_frame(0);
        pulse_start(0, sc);
        wait_frames(0, 3);
        cont = 1'b0;
        wait_idle(0, hc);
        check("cont_frames", fr_cnt[0], 3);
        check_frame(0, 1, 30, 8);
        check_frame(0, 2, 30, 8);
        check("cont_vsync_gap", rec_rise[0][2] - rec_fall[0][1], 12);
        check("cont_frame_done", fd_cnt[0], 3);

        push_frame(0);
        pulse_start(0, sc);
        for (int i = 0; i < 100 && !ifa.img_href; i++) @(negedge clk);
        pulse_start(0, sc2);
        wait_idle(0, hc);
        check_idle("no_extra_frame", 20);
        check("busy_start_frames", fr_cnt[0], 4);
        check("busy_start_frame_done", fd_cnt[0], 4);
        check_frame(0, 3, 30, 8);

        push_frame(0);
        pulse_start(0, sc);
        for (int i = 0; i < 100 && exp_px0.size() > 6; i++) @(negedge clk);
        @(posedge clk); #2; rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_px0.delete();
        repeat (3) @(negedge clk);
        @(posedge clk); #2; rst_n = 1'b1;
        check_idle("idle_after_midreset", 20);
        push_frame(0);
        pulse_start(0, sc);
        wait_idle(0, hc);
        check("post_reset_frames", fr_cnt[0], 5);
        check("post_reset_frame_done", fd_cnt[0], 5);
        check_frame(0, 4, 30, 8);

        push_frame(1);
        pulse_start(1, sc);
        wait_idle(1, hc);
        check("vpost0_busy_len", hc, 36);
        check("vpost0_frames", fr_cnt[1], 1);
        check_frame(1, 0, 24, 2);
        check("vpost0_frame_done", fd_cnt[1], 1);

        repeat (4) @(negedge clk);
        check("px_queue_a_left", exp_px0.size(), 0);
        check("px_queue_b_left", exp_px1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
